// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo setpoint path.
package servo_pkg;

    // state    | meaning
    // ST_IDLE  | servo released, position held, waiting for ENABLE
    // ST_ARM   | drive requested, waiting for a frame boundary
    // ST_RUN   | generator enabled, ramp updates on each frame tick
    // ST_DRAIN | generator released, waiting out the current frame
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } servo_state_t;

    localparam int C_FRAME_US_DEF  = 20000;
    localparam int C_PWM_FREQ_DEF  = 100;
    localparam int C_FRAME_CYCLES  = C_FRAME_US_DEF * C_PWM_FREQ_DEF;

    // Counter width able to hold 0..cycles-1; never narrower than one bit.
    function automatic int frame_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter with a registered one-cycle boundary tick.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int C_CYCLES = C_FRAME_CYCLES
) (
    input  logic CLK,
    input  logic nRST,
    output logic frame_tick_o
);

    localparam int              W      = frame_cnt_width(C_CYCLES);
    localparam logic [W-1:0]    C_LAST = W'(C_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Wrap at the last count and flag the boundary for the following cycle.
    always_comb begin
        tick_d = (cnt_q == C_LAST);
        cnt_d  = tick_d ? '0 : cnt_q + W'(1);
    end

    // Counter and tick registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick_o = tick_q;

endmodule

// File: rtl/servo_setpoint_ramp.sv
// Accepts position targets and slews the generator command toward them,
// one bounded step per servo frame, changing PWM_IN only at frame boundaries.
//
// state    | meaning
// ST_IDLE  | EN=0, position held; ENABLE=1 -> ST_ARM
// ST_ARM   | EN=0, wait for tick -> ST_RUN; ENABLE=0 -> ST_IDLE
// ST_RUN   | EN=1, ramp active; ENABLE=0 -> ST_DRAIN
// ST_DRAIN | EN=0, at tick -> ST_IDLE (ST_ARM if ENABLE=1)
module servo_setpoint_ramp
    import servo_pkg::*;
#(
    parameter int C_PWM_SIZE   = 8,
    parameter int C_PWM_FREQ   = C_PWM_FREQ_DEF,
    parameter int C_PWM_MAX_IN = 200,
    parameter int C_FRAME_US   = C_FRAME_US_DEF,
    parameter int C_POS_RESET  = 100
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ENABLE,
    input  logic                  TGT_VALID,
    output logic                  TGT_READY,
    input  logic [C_PWM_SIZE-1:0] TGT_POS,
    input  logic [C_PWM_SIZE-1:0] STEP,
    output logic [C_PWM_SIZE-1:0] PWM_IN,
    output logic                  EN,
    output logic                  FRAME_TICK,
    output logic                  AT_TARGET
);

    localparam int                  W     = C_PWM_SIZE;
    localparam logic [W-1:0]        C_MAX = W'(C_PWM_MAX_IN);
    localparam logic [W-1:0]        C_RST = W'(C_POS_RESET);

    servo_state_t   state_q, state_d;
    logic           pend_vld_q, pend_vld_d;
    logic [W-1:0]   pend_pos_q, pend_pos_d;
    logic [W-1:0]   act_q, act_d;
    logic [W-1:0]   pwm_q, pwm_d;

    logic           tick;
    logic           accept;
    logic [W-1:0]   pos_sat;
    logic [W-1:0]   tgt_eff;
    logic [W:0]     sum_up;
    logic signed [W+1:0] diff_dn;

    servo_frame_timer #(
        .C_CYCLES (C_FRAME_US * C_PWM_FREQ)
    ) u_frame_timer (
        .CLK          (CLK),
        .nRST         (nRST),
        .frame_tick_o (tick)
    );

    // Next-state logic for the drive sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ENABLE) state_d = ST_ARM;
            ST_ARM: begin
                if (!ENABLE)   state_d = ST_IDLE;
                else if (tick) state_d = ST_RUN;
            end
            ST_RUN:   if (!ENABLE) state_d = ST_DRAIN;
            ST_DRAIN: if (tick) state_d = ENABLE ? ST_ARM : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake slot, target transfer and bounded ramp step on frame ticks.
    always_comb begin
        pos_sat    = (TGT_POS > C_MAX) ? C_MAX : TGT_POS;
        accept     = TGT_VALID & ~pend_vld_q;
        tgt_eff    = (tick && pend_vld_q) ? pend_pos_q : act_q;
        // One extra bit up, two extra bits signed down: no wrap either way.
        sum_up     = {1'b0, pwm_q} + {1'b0, STEP};
        diff_dn    = $signed({2'b00, pwm_q}) - $signed({2'b00, STEP});
        pend_vld_d = pend_vld_q;
        pend_pos_d = pend_pos_q;
        act_d      = act_q;
        pwm_d      = pwm_q;

        if (accept) begin
            pend_vld_d = 1'b1;
            pend_pos_d = pos_sat;
        end else if (tick) begin
            pend_vld_d = 1'b0;
        end

        if (tick) begin
            act_d = tgt_eff;
            if (state_q == ST_RUN) begin
                if (STEP == '0) begin
                    pwm_d = tgt_eff;
                end else if (pwm_q < tgt_eff) begin
                    pwm_d = (sum_up > {1'b0, tgt_eff}) ? tgt_eff : sum_up[W-1:0];
                end else if (pwm_q > tgt_eff) begin
                    pwm_d = (diff_dn < $signed({2'b00, tgt_eff})) ? tgt_eff : diff_dn[W-1:0];
                end
            end
        end
    end

    // State, slot and position registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= ST_IDLE;
            pend_vld_q <= 1'b0;
            pend_pos_q <= '0;
            act_q      <= C_RST;
            pwm_q      <= C_RST;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_pos_q <= pend_pos_d;
            act_q      <= act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign EN         = (state_q == ST_RUN);
    assign TGT_READY  = ~pend_vld_q;
    assign PWM_IN     = pwm_q;
    assign FRAME_TICK = tick;
    assign AT_TARGET  = (pwm_q == act_q);

endmodule

// File: tb/tb_servo_setpoint_ramp.sv
// Bench for servo_setpoint_ramp with 20-cycle frames, directed scenarios
// followed by randomized traffic against a behavioural reference.
module tb_servo_setpoint_ramp;

    localparam int FRAME = 20;
    localparam int PMAX  = 200;
    localparam int PRST  = 100;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic       CLK;
    logic       nRST;
    logic       ENABLE;
    logic       TGT_VALID;
    logic       TGT_READY;
    logic [7:0] TGT_POS;
    logic [7:0] STEP;
    logic [7:0] PWM_IN;
    logic       EN;
    logic       FRAME_TICK;
    logic       AT_TARGET;

    int n_chk  = 0;
    int n_fail = 0;

    // reference state
    bit m_live = 0;
    int m_cyc, m_pend_v, m_pend, m_act, m_pwm, m_mode;

    servo_setpoint_ramp #(
        .C_PWM_SIZE   (8),
        .C_PWM_FREQ   (1),
        .C_PWM_MAX_IN (PMAX),
        .C_FRAME_US   (FRAME),
        .C_POS_RESET  (PRST)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ENABLE     (ENABLE),
        .TGT_VALID  (TGT_VALID),
        .TGT_READY  (TGT_READY),
        .TGT_POS    (TGT_POS),
        .STEP       (STEP),
        .PWM_IN     (PWM_IN),
        .EN         (EN),
        .FRAME_TICK (FRAME_TICK),
        .AT_TARGET  (AT_TARGET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_tick();
        return m_live && (m_cyc > 0) && (m_cyc % FRAME == 0);
    endfunction

    // Slew rule: move toward target by at most step, never past it; step 0 jumps.
    function automatic int ramp(input int pos, input int tgt, input int step);
        if (step == 0)  return tgt;
        if (pos < tgt)  return (pos + step > tgt) ? tgt : pos + step;
        if (pos > tgt)  return (pos - step < tgt) ? tgt : pos - step;
        return pos;
    endfunction

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_edge();
        bit tick, accept;
        int tgt;
        if (nRST) begin
            m_live = 1; m_cyc = 0; m_pend_v = 0; m_pend = 0;
            m_act = PRST; m_pwm = PRST; m_mode = M_IDLE;
            return;
        end
        if (!m_live) return;
        tick   = m_tick();
        accept = TGT_VALID && !m_pend_v;
        tgt    = (tick && m_pend_v) ? m_pend : m_act;
        if (tick && m_mode == M_RUN) m_pwm = ramp(m_pwm, tgt, int'(STEP));
        if (tick) m_act = tgt;
        case (m_mode)
            M_IDLE:  if (ENABLE) m_mode = M_ARM;
            M_ARM:   if (!ENABLE) m_mode = M_IDLE; else if (tick) m_mode = M_RUN;
            M_RUN:   if (!ENABLE) m_mode = M_DRAIN;
            default: if (tick) m_mode = ENABLE ? M_ARM : M_IDLE;
        endcase
        if (accept) begin
            m_pend_v = 1;
            m_pend   = (int'(TGT_POS) > PMAX) ? PMAX : int'(TGT_POS);
        end else if (tick) begin
            m_pend_v = 0;
        end
        m_cyc++;
    endtask

    // Compare at the falling edge, step the reference, then cross the rising edge.
    task automatic clk1();
        @(negedge CLK);
        if (m_live) begin
            chk("pwm",   int'(PWM_IN),     m_pwm);
            chk("en",    int'(EN),         (m_mode == M_RUN) ? 1 : 0);
            chk("tick",  int'(FRAME_TICK), m_tick() ? 1 : 0);
            chk("ready", int'(TGT_READY),  m_pend_v ? 0 : 1);
            chk("at",    int'(AT_TARGET),  (m_pwm == m_act) ? 1 : 0);
        end
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic offer(input int pos);
        TGT_VALID = 1'b1;
        TGT_POS   = 8'(pos);
        clk1();
        TGT_VALID = 1'b0;
    endtask

    initial begin
        bit found;
        nRST = 1'b1; ENABLE = 1'b0; TGT_VALID = 1'b0; TGT_POS = '0; STEP = '0;
        run(2);
        nRST = 1'b0;
        chk("rst_pwm",   int'(PWM_IN),     PRST);
        chk("rst_en",    int'(EN),         0);
        chk("rst_ready", int'(TGT_READY),  1);
        chk("rst_at",    int'(AT_TARGET),  1);
        chk("rst_tick",  int'(FRAME_TICK), 0);

        // arm mid-frame, run through the first boundary
        run(5);
        ENABLE = 1'b1;
        run(40);
        chk("run_en", int'(EN), 1);

        // upward ramp 100 -> 150 in steps of 20
        STEP = 8'd20;
        offer(150);
        run(70);
        chk("ramp_up_pwm", int'(PWM_IN), 150);
        chk("ramp_up_at",  int'(AT_TARGET), 1);

        // saturation of an out-of-range target with direct jump
        STEP = 8'd0;
        offer(250);
        run(30);
        chk("sat_pwm", int'(PWM_IN), PMAX);

        // downward ramp with no underflow
        offer(100);
        run(30);
        STEP = 8'd40;
        offer(10);
        run(70);
        chk("ramp_dn_pwm", int'(PWM_IN), 10);

        // back-to-back targets: second stalls until the slot frees
        STEP = 8'd0;
        offer(50);
        chk("stall_ready", int'(TGT_READY), 0);
        TGT_VALID = 1'b1;
        TGT_POS   = 8'd180;
        run(25);
        TGT_VALID = 1'b0;
        run(30);
        chk("b2b_pwm", int'(PWM_IN), 180);

        // release: EN drops next cycle, then drain to idle
        ENABLE = 1'b0;
        clk1();
        chk("drain_en", int'(EN), 0);
        run(25);

        // reset in the middle of a downward ramp
        ENABLE = 1'b1;
        STEP   = 8'd20;
        offer(100);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (PWM_IN == 8'd140) begin
                found = 1;
                break;
            end
            clk1();
        end
        chk("reach140", int'(PWM_IN), 140);
        if (found) offer(30);
        nRST = 1'b1;
        clk1();
        nRST = 1'b0;
        chk("mid_rst_pwm",   int'(PWM_IN),    PRST);
        chk("mid_rst_en",    int'(EN),        0);
        chk("mid_rst_ready", int'(TGT_READY), 1);
        chk("mid_rst_at",    int'(AT_TARGET), 1);
        run(45);
        chk("mid_rst_hold", int'(PWM_IN), PRST);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nRST = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) ENABLE = ~ENABLE;
            TGT_VALID = ($urandom_range(0, 3) == 0);
            TGT_POS   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       STEP = 8'd0;
                    1:       STEP = 8'($urandom_range(200, 255));
                    default: STEP = 8'($urandom_range(1, 80));
                endcase
            end
            clk1();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
